// File: rtl/uart_cmd_ctrl.sv
// Command sequencer behind the UART receiver: frames SYNC/CMD/ADDR/DATA[/CSUM] into register-bus accesses.
// Define UART_CMD_CSUM_EN to add the trailing checksum byte and its check.
module uart_cmd_ctrl #(
   parameter logic [7:0] SYNC_BYTE = 8'h55,
   parameter int         TIMEOUT   = 4096,
   parameter int         ADDR_W    = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ack,
   output logic              reg_wr,
   output logic              reg_rd,
   output logic [ADDR_W-1:0] reg_addr,
   output logic [7:0]        reg_wdata,
   input  logic [7:0]        reg_rdata,
   output logic [7:0]        tx_data,
   output logic              tx_valid,
   input  logic              tx_ready,
   output logic [7:0]        err_cnt
);

   localparam int TMR_W = $clog2(TIMEOUT + 1);

   localparam logic [7:0] CMD_WR   = 8'h01;
   localparam logic [7:0] CMD_RD   = 8'h02;
   localparam logic [7:0] RESP_OK  = 8'hAC;
   localparam logic [7:0] RESP_ERR = 8'hEE;

   typedef enum logic [2:0] {
      S_SYNC, S_CMD, S_ADDR, S_DATA, S_CSUM, S_EXEC, S_RDWAIT, S_RESP
   } state_t;

   state_t            state_q, state_d;
   logic              armed_q, armed_d;
   logic              rx_ack_q, rx_ack_d;
   logic              reg_wr_q, reg_wr_d;
   logic              reg_rd_q, reg_rd_d;
   logic [ADDR_W-1:0] reg_addr_q, reg_addr_d;
   logic [7:0]        reg_wdata_q, reg_wdata_d;
   logic [7:0]        tx_data_q, tx_data_d;
   logic              tx_valid_q, tx_valid_d;
   logic [7:0]        err_cnt_q, err_cnt_d;
   logic [TMR_W-1:0]  timer_q, timer_d;
   logic              cmd_rd_q, cmd_rd_d;
   logic [7:0]        addr_q, addr_d;
   logic [7:0]        data_q, data_d;
`ifdef UART_CMD_CSUM_EN
   logic [7:0]        cmd_q, cmd_d;
`endif

   logic in_frame;
   logic accept;
   logic timeout;

   function automatic logic [7:0] err_inc(input logic [7:0] cnt);
      return (cnt == 8'hFF) ? 8'hFF : cnt + 8'd1;
   endfunction

   always_comb begin
      state_d     = state_q;
      armed_d     = armed_q;
      rx_ack_d    = rx_ack_q;
      reg_wr_d    = 1'b0;
      reg_rd_d    = 1'b0;
      reg_addr_d  = reg_addr_q;
      reg_wdata_d = reg_wdata_q;
      tx_data_d   = tx_data_q;
      tx_valid_d  = tx_valid_q;
      err_cnt_d   = err_cnt_q;
      timer_d     = '0;
      cmd_rd_d    = cmd_rd_q;
      addr_d      = addr_q;
      data_d      = data_q;
`ifdef UART_CMD_CSUM_EN
      cmd_d       = cmd_q;
`endif

      in_frame = (state_q == S_CMD) || (state_q == S_ADDR) ||
                 (state_q == S_DATA) || (state_q == S_CSUM);
      // Bytes are only taken while hunting for SYNC or collecting a frame.
      accept  = rx_valid && armed_q && (in_frame || (state_q == S_SYNC));
      timeout = in_frame && !accept && (timer_q == TMR_W'(TIMEOUT - 1));

      if (accept) begin
         rx_ack_d = 1'b1;
         armed_d  = 1'b0;
      end else if (!armed_q && !rx_valid) begin
         rx_ack_d = 1'b0;
         armed_d  = 1'b1;
      end

      if (in_frame && !accept) begin
         timer_d = timer_q + 1'b1;
      end

      case (state_q)
         S_SYNC: begin
            if (accept && (rx_data == SYNC_BYTE)) begin
               state_d = S_CMD;
            end
         end
         S_CMD: begin
            if (accept) begin
               if ((rx_data == CMD_WR) || (rx_data == CMD_RD)) begin
                  cmd_rd_d = (rx_data == CMD_RD);
`ifdef UART_CMD_CSUM_EN
                  cmd_d    = rx_data;
`endif
                  state_d  = S_ADDR;
               end else begin
                  err_cnt_d = err_inc(err_cnt_q);
                  tx_data_d = RESP_ERR;
                  state_d   = S_RESP;
               end
            end
         end
         S_ADDR: begin
            if (accept) begin
               addr_d  = rx_data;
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (accept) begin
               data_d  = rx_data;
`ifdef UART_CMD_CSUM_EN
               state_d = S_CSUM;
`else
               state_d = S_EXEC;
`endif
            end
         end
         S_CSUM: begin
`ifdef UART_CMD_CSUM_EN
            if (accept) begin
               if (rx_data == 8'(cmd_q + addr_q + data_q)) begin
                  state_d = S_EXEC;
               end else begin
                  err_cnt_d = err_inc(err_cnt_q);
                  tx_data_d = RESP_ERR;
                  state_d   = S_RESP;
               end
            end
`else
            state_d = S_SYNC;
`endif
         end
         S_EXEC: begin
            reg_addr_d = addr_q[ADDR_W-1:0];
            if (cmd_rd_q) begin
               reg_rd_d = 1'b1;
               state_d  = S_RDWAIT;
            end else begin
               reg_wr_d    = 1'b1;
               reg_wdata_d = data_q;
               tx_data_d   = RESP_OK;
               state_d     = S_RESP;
            end
         end
         S_RDWAIT: begin
            // Read data is valid the cycle after the strobe has dropped.
            if (!reg_rd_q) begin
               tx_data_d = reg_rdata;
               state_d   = S_RESP;
            end
         end
         S_RESP: begin
            if (!tx_valid_q) begin
               tx_valid_d = 1'b1;
            end else if (tx_ready) begin
               tx_valid_d = 1'b0;
               state_d    = S_SYNC;
            end
         end
         default: state_d = S_SYNC;
      endcase

      if (timeout) begin
         err_cnt_d = err_inc(err_cnt_q);
         state_d   = S_SYNC;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_SYNC;
         armed_q     <= 1'b1;
         rx_ack_q    <= 1'b0;
         reg_wr_q    <= 1'b0;
         reg_rd_q    <= 1'b0;
         reg_addr_q  <= '0;
         reg_wdata_q <= '0;
         tx_data_q   <= '0;
         tx_valid_q  <= 1'b0;
         err_cnt_q   <= '0;
         timer_q     <= '0;
         cmd_rd_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         armed_q     <= armed_d;
         rx_ack_q    <= rx_ack_d;
         reg_wr_q    <= reg_wr_d;
         reg_rd_q    <= reg_rd_d;
         reg_addr_q  <= reg_addr_d;
         reg_wdata_q <= reg_wdata_d;
         tx_data_q   <= tx_data_d;
         tx_valid_q  <= tx_valid_d;
         err_cnt_q   <= err_cnt_d;
         timer_q     <= timer_d;
         cmd_rd_q    <= cmd_rd_d;
      end
   end

   // Frame payload holding registers need no reset; they are rewritten before use.
   always_ff @(posedge clk) begin
      addr_q <= addr_d;
      data_q <= data_d;
`ifdef UART_CMD_CSUM_EN
      cmd_q  <= cmd_d;
`endif
   end

   assign rx_ack    = rx_ack_q;
   assign reg_wr    = reg_wr_q;
   assign reg_rd    = reg_rd_q;
   assign reg_addr  = reg_addr_q;
   assign reg_wdata = reg_wdata_q;
   assign tx_data   = tx_data_q;
   assign tx_valid  = tx_valid_q;
   assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed bench for uart_cmd_ctrl: frames, errors, timeout, handshakes, saturation and mid-frame reset.
module tb_uart_cmd_ctrl;
   localparam int TIMEOUT = 4096;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] rx_data = 8'h00;
   logic       rx_valid = 1'b0;
   logic       rx_ack;
   logic       reg_wr, reg_rd;
   logic [7:0] reg_addr, reg_wdata;
   logic [7:0] reg_rdata = 8'h00;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready = 1'b1;
   logic [7:0] err_cnt;

   uart_cmd_ctrl #(.SYNC_BYTE(8'h55), .TIMEOUT(TIMEOUT), .ADDR_W(8)) dut (
      .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ack(rx_ack),
      .reg_wr(reg_wr), .reg_rd(reg_rd), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
      .reg_rdata(reg_rdata), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int wr_cnt = 0, rd_cnt = 0, tx_cnt = 0, ack_rises = 0;
   int wr_cyc = 0, txv_cyc = 0, ack_cyc = 0;
   logic [7:0] wr_addr = 8'h00, wr_data = 8'h00, rd_addr = 8'h00, tx_last = 8'h00;
   logic txv_prev = 1'b0, ack_prev = 1'b0, rd_prev = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   // Bus/transmitter observer plus a register slave that returns 5A only in the cycle after reg_rd.
   always @(negedge clk) begin
      if (reg_wr) begin wr_cnt++; wr_addr = reg_addr; wr_data = reg_wdata; wr_cyc = cyc; end
      if (reg_rd) begin rd_cnt++; rd_addr = reg_addr; end
      if (tx_valid && !txv_prev) txv_cyc = cyc;
      if (tx_valid && tx_ready) begin tx_cnt++; tx_last = tx_data; end
      if (rx_ack && !ack_prev) begin ack_rises++; ack_cyc = cyc; end
      txv_prev  = tx_valid;
      ack_prev  = rx_ack;
      reg_rdata = rd_prev ? 8'h5A : 8'h00;
      rd_prev   = reg_rd;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n;
      rx_data = b;
      rx_valid = 1'b1;
      n = 0;
      while (!rx_ack && n < 50) begin tick(); n++; end
      if (!rx_ack) check("ack_rise", {31'd0, rx_ack}, 32'd1);
      rx_valid = 1'b0;
      n = 0;
      while (rx_ack && n < 50) begin tick(); n++; end
      if (rx_ack) check("ack_fall", {31'd0, rx_ack}, 32'd0);
   endtask

   task automatic send_frame(input logic [7:0] cmd, input logic [7:0] addr,
                             input logic [7:0] data, input logic [7:0] csum);
      send_byte(8'h55);
      send_byte(cmd);
      send_byte(addr);
      send_byte(data);
`ifdef UART_CMD_CSUM_EN
      send_byte(csum);
`else
      if (csum == 8'hXX) tick();
`endif
   endtask

   task automatic wait_tx(input int prev, input string tag);
      int n;
      n = 0;
      while (tx_cnt == prev && n < 200) begin tick(); n++; end
      if (tx_cnt == prev) check(tag, tx_cnt, prev + 1);
      tick();
   endtask

   int exp_err;
   int t0, w0, r0, a0;
   logic stable;

   initial begin
      repeat (3) tick();
      check("rst_ack",   {31'd0, rx_ack}, 32'd0);
      check("rst_strb",  {30'd0, reg_wr, reg_rd}, 32'd0);
      check("rst_bus",   {16'd0, reg_addr, reg_wdata}, 32'd0);
      check("rst_tx",    {23'd0, tx_valid, tx_data}, 32'd0);
      check("rst_err",   err_cnt, 32'd0);
      rst = 1'b0;
      tick();
      exp_err = 0;

      // Garbage ahead of SYNC, then a write
      send_byte(8'h00);
      send_byte(8'hFF);
      check("garbage_err", err_cnt, 32'd0);
      t0 = tx_cnt;
      send_frame(8'h01, 8'h10, 8'h3C, 8'h4D);
      wait_tx(t0, "wr_resp_timeout");
      check("wr_cnt",   wr_cnt, 32'd1);
      check("wr_addr",  wr_addr, 32'h10);
      check("wr_data",  wr_data, 32'h3C);
      check("wr_resp",  tx_last, 32'hAC);
      check("wr_err",   err_cnt, 32'd0);
      check("wr_lat",   wr_cyc - ack_cyc, 32'd1);
      check("txv_lat",  txv_cyc - wr_cyc, 32'd1);

      // Read
      t0 = tx_cnt;
      send_frame(8'h02, 8'h07, 8'h00, 8'h09);
      wait_tx(t0, "rd_resp_timeout");
      check("rd_cnt",   rd_cnt, 32'd1);
      check("rd_addr",  rd_addr, 32'h07);
      check("rd_resp",  tx_last, 32'h5A);
      check("rd_no_wr", wr_cnt, 32'd1);

`ifdef UART_CMD_CSUM_EN
      // Bad checksum
      t0 = tx_cnt;
      send_frame(8'h01, 8'h10, 8'h3C, 8'h00);
      wait_tx(t0, "csum_resp_timeout");
      exp_err++;
      check("csum_no_wr", wr_cnt, 32'd1);
      check("csum_resp",  tx_last, 32'hEE);
      check("csum_err",   err_cnt, exp_err);
`endif

      // Bad command
      t0 = tx_cnt;
      send_byte(8'h55);
      send_byte(8'h07);
      wait_tx(t0, "cmd_resp_timeout");
      exp_err++;
      check("badcmd_resp", tx_last, 32'hEE);
      check("badcmd_err",  err_cnt, exp_err);

      // Inter-byte timeout
      t0 = tx_cnt;
      send_byte(8'h55);
      send_byte(8'h01);
      repeat (TIMEOUT - 10) tick();
      check("to_early_err", err_cnt, exp_err);
      repeat (20) tick();
      exp_err++;
      check("to_err",  err_cnt, exp_err);
      check("to_no_tx", tx_cnt, t0);
      check("to_txv",  {31'd0, tx_valid}, 32'd0);
      send_frame(8'h01, 8'h22, 8'h11, 8'h34);
      wait_tx(t0, "to_resp_timeout");
      check("to_wr_addr", wr_addr, 32'h22);
      check("to_wr_cnt",  wr_cnt, 32'd2);

      // Held rx_valid and stalled transmitter
      a0 = ack_rises;
      rx_data = 8'h55;
      rx_valid = 1'b1;
      repeat (20) tick();
      check("hold_ack",   {31'd0, rx_ack}, 32'd1);
      check("hold_once",  ack_rises - a0, 32'd1);
      rx_valid = 1'b0;
      repeat (2) tick();
      check("hold_ack_low", {31'd0, rx_ack}, 32'd0);
      tx_ready = 1'b0;
      t0 = tx_cnt;
      send_byte(8'h01);
      send_byte(8'h44);
      send_byte(8'hAA);
`ifdef UART_CMD_CSUM_EN
      send_byte(8'hEF);
`endif
      for (int n = 0; n < 50 && !tx_valid; n++) tick();
      stable = tx_valid;
      for (int n = 0; n < 50; n++) begin
         tick();
         if (!tx_valid || tx_data !== 8'hAC) stable = 1'b0;
      end
      check("stall_stable", {31'd0, stable}, 32'd1);
      check("stall_no_tx",  tx_cnt, t0);
      check("stall_wr",     wr_addr, 32'h44);
      check("stall_err",    err_cnt, exp_err);
      tx_ready = 1'b1;
      tick();
      check("stall_done",   tx_cnt, t0 + 1);
      check("stall_txv",    {31'd0, tx_valid}, 32'd0);

      // Saturation
      for (int i = 0; i < 300; i++) begin
         t0 = tx_cnt;
         send_byte(8'h55);
         send_byte(8'h03);
         wait_tx(t0, "sat_resp_timeout");
      end
      check("sat_err", err_cnt, 32'hFF);

      // Reset mid-frame
      send_byte(8'h55);
      send_byte(8'h01);
      send_byte(8'h10);
      rst = 1'b1;
      tick();
      check("mrst_err",  err_cnt, 32'd0);
      check("mrst_bus",  {16'd0, reg_addr, reg_wdata}, 32'd0);
      check("mrst_tx",   {23'd0, tx_valid, tx_data}, 32'd0);
      check("mrst_ack",  {29'd0, rx_ack, reg_wr, reg_rd}, 32'd0);
      rst = 1'b0;
      tick();
      w0 = wr_cnt;
      r0 = rd_cnt;
      t0 = tx_cnt;
      send_frame(8'h01, 8'h5A, 8'h0F, 8'h6A);
      wait_tx(t0, "mrst_resp_timeout");
      check("mrst_wr_cnt",  wr_cnt, w0 + 1);
      check("mrst_wr_addr", wr_addr, 32'h5A);
      check("mrst_wr_data", wr_data, 32'h0F);
      check("mrst_resp",    tx_last, 32'hAC);
      check("mrst_no_rd",   rd_cnt, r0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
